// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg : shared FSM encoding and sizing helper for the sequential adder
// Revision  : 1.0
// ============================================================================
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// adder_chunk : combinational W-bit add with carry into and out of the MSB
// Revision    : 1.0
// ============================================================================
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    // The MSB sum bit is a^b^carry_in, so the carry into it falls out directly.
    assign c_msb_in = s[W-1] ^ a[W-1] ^ b[W-1];

endmodule : adder_chunk
`default_nettype wire

// File: rtl/adder_nbit_seq.sv
`default_nettype none
// ============================================================================
// adder_nbit_seq : multi-cycle N-bit add/subtract, W bits per clock, LSB first
// Revision       : 1.0
// ============================================================================
module adder_nbit_seq
    import adder_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int              c_K    = N / W;
    localparam int              c_CW   = (clog2(c_K) < 1) ? 1 : clog2(c_K);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_K - 1);

    logic [1:0]      r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_work;
    logic            r_carry;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [W-1:0]    w_a_chunk;
    logic [W-1:0]    w_b_chunk;
    logic [W-1:0]    w_s;
    logic            w_cout;
    logic            w_c_msb;
    logic [N-1:0]    w_work_next;

    assign w_a_chunk = r_a[int'(r_cnt) * W +: W];
    assign w_b_chunk = r_b[int'(r_cnt) * W +: W];

    adder_chunk #(.W(W)) u_chunk (
        .a        (w_a_chunk),
        .b        (w_b_chunk),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_cout),
        .c_msb_in (w_c_msb)
    );

    // Working word with the current chunk merged in, so the final edge can
    // publish the complete result without an extra cycle.
    always_comb begin
        w_work_next = r_work;
        w_work_next[int'(r_cnt) * W +: W] = w_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtraction is x + ~y + ~borrow_in.
                        r_a     <= x;
                        r_b     <= sub ? ~y : y;
                        r_carry <= c_in ^ sub;
                        r_cnt   <= '0;
                        r_work  <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_cout;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_sum   <= w_work_next;
                        r_cout  <= w_cout;
                        r_ovf   <= w_c_msb ^ w_cout;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign c_out = r_cout;
    assign ovf   = r_ovf;

endmodule : adder_nbit_seq
`default_nettype wire

// File: tb/tb_adder_nbit_seq.sv
`default_nettype none
// ============================================================================
// tb_adder_nbit_seq : directed + random checks of four adder_nbit_seq configs
// Revision          : 1.0
// ============================================================================
module tb_adder_nbit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0;
    logic        sub = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        c_in = 1'b0;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  c_out;
    logic [3:0]  ovf;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [15:0] sum2;
    logic [31:0] sum3;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_nbit_seq #(.N(16), .W(4)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .x(x[15:0]), .y(y[15:0]),
        .c_in(c_in), .busy(busy[0]), .done(done[0]), .sum(sum0), .c_out(c_out[0]), .ovf(ovf[0]));
    adder_nbit_seq #(.N(8), .W(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .x(x[7:0]), .y(y[7:0]),
        .c_in(c_in), .busy(busy[1]), .done(done[1]), .sum(sum1), .c_out(c_out[1]), .ovf(ovf[1]));
    adder_nbit_seq #(.N(16), .W(16)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .x(x[15:0]), .y(y[15:0]),
        .c_in(c_in), .busy(busy[2]), .done(done[2]), .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2]));
    adder_nbit_seq #(.N(32), .W(8)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .sub(sub), .x(x), .y(y),
        .c_in(c_in), .busy(busy[3]), .done(done[3]), .sum(sum3), .c_out(c_out[3]), .ovf(ovf[3]));

    function automatic int n_of(input int i);
        case (i)
            0: return 16;
            1: return 8;
            2: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int k_of(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int i);
        case (i)
            0: return {16'h0, sum0};
            1: return {24'h0, sum1};
            2: return {16'h0, sum2};
            default: return sum3;
        endcase
    endfunction

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic logic [33:0] ref_op(input int n, input logic s, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
        longint mask, ua, ub, sa, sb, r, sr, smax, smin, cil;
        logic [33:0] res;
        mask = (longint'(1) << n) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (((ua >> (n - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
        sb   = (((ub >> (n - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
        smax = (longint'(1) << (n - 1)) - 1;
        smin = -(smax + 1);
        cil  = ci ? 1 : 0;
        if (!s) begin
            r  = ua + ub + cil;
            sr = sa + sb + cil;
        end else begin
            r  = ua - ub - cil;
            sr = sa - sb - cil;
        end
        res[31:0] = 32'(r & mask);
        res[32]   = s ? (r >= 0) : (((r >> n) & 1) != 0);
        res[33]   = (sr > smax) || (sr < smin);
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int i, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        sub = s; x = a; y = b; c_in = ci;
        start[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Entered at the negedge after the accepting edge; counts edges until done.
    task automatic wait_done(input int i, output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (!done[i] && lat < 100) begin
            if (busy[i]) nb++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done[i]) chk("timeout", 64'(lat), 64'(k_of(i)));
    endtask

    task automatic check_res(input int i, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic ci, input string tag);
        logic [33:0] e;
        e = ref_op(n_of(i), s, a, b, ci);
        chk({tag, ".sum"},  64'(get_sum(i)), 64'(e[31:0]));
        chk({tag, ".cout"}, 64'(c_out[i]),   64'(e[32]));
        chk({tag, ".ovf"},  64'(ovf[i]),     64'(e[33]));
    endtask

    task automatic do_op(input int i, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input string tag);
        int lat, nb;
        issue(i, s, a, b, ci);
        wait_done(i, lat, nb);
        chk({tag, ".lat"},  64'(lat), 64'(k_of(i)));
        chk({tag, ".busy"}, 64'(nb),  64'(k_of(i)));
        check_res(i, s, a, b, ci, tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".pulse"}, 64'(done[i]), 64'd0);
    endtask

    initial begin
        int lat, nb, ndone;
        logic [31:0] ra, rb;
        logic rs, rc;

        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst.busy", 64'(busy[i]), 64'd0);
            chk("rst.done", 64'(done[i]), 64'd0);
            chk("rst.sum",  64'(get_sum(i)), 64'd0);
            chk("rst.flag", 64'({c_out[i], ovf[i]}), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 1'b0, 32'h1234, 32'h0FCD, 1'b1, "add");
        chk("add.exact", 64'({ovf[0], c_out[0], sum0}), 64'h0_2202);
        do_op(0, 1'b0, 32'hFFFF, 32'h0001, 1'b0, "ripple");
        chk("ripple.exact", 64'({ovf[0], c_out[0], sum0}), 64'h1_0000);
        do_op(0, 1'b1, 32'h8000, 32'h0001, 1'b0, "subovf");
        chk("subovf.exact", 64'({ovf[0], c_out[0], sum0}), 64'h3_7FFF);
        do_op(0, 1'b1, 32'h0003, 32'h0005, 1'b0, "subneg");
        chk("subneg.exact", 64'({ovf[0], c_out[0], sum0}), 64'h0_FFFE);

        // start pulsed mid-operation must not disturb the running one
        issue(0, 1'b0, 32'h1111, 32'h2222, 1'b0);
        @(posedge clk);
        @(negedge clk);
        issue(0, 1'b1, 32'h7777, 32'h0001, 1'b1);
        wait_done(0, lat, nb);
        check_res(0, 1'b0, 32'h1111, 32'h2222, 1'b0, "ignore");
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("ignore.nodone", 64'(ndone), 64'd0);

        // start held through DONE: second op accepted in the DONE cycle
        sub = 1'b0; x = 32'h00F0; y = 32'h0F0F; c_in = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(0, lat, nb);
        chk("hold1.lat", 64'(lat), 64'd4);
        check_res(0, 1'b0, 32'h00F0, 32'h0F0F, 1'b0, "hold1");
        sub = 1'b1; x = 32'h7FFF; y = 32'hFFFF; c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, lat, nb);
        chk("hold2.gap", 64'(lat + 1), 64'd5);
        check_res(0, 1'b1, 32'h7FFF, 32'hFFFF, 1'b0, "hold2");

        // asynchronous reset in the middle of a run
        @(negedge clk);
        issue(0, 1'b0, 32'h4321, 32'h1234, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("mid.busy_before", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid.busy", 64'(busy[0]), 64'd0);
        chk("mid.done", 64'(done[0]), 64'd0);
        chk("mid.sum",  64'(sum0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0] || busy[0]) ndone++;
        end
        chk("mid.quiet", 64'(ndone), 64'd0);
        do_op(0, 1'b0, 32'h4321, 32'h1234, 1'b1, "after_rst");

        for (int t = 0; t < 40; t++) begin
            ra = $urandom; rb = $urandom;
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            do_op(0, rs, ra, rb, rc, "rnd16x4");
        end
        for (int i = 1; i < 4; i++) begin
            for (int t = 0; t < 200; t++) begin
                ra = $urandom; rb = $urandom;
                rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
                do_op(i, rs, ra, rb, rc, "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule : tb_adder_nbit_seq
`default_nettype wire
